keypad_scanner: RTL

- Front end of the key-entry path. Scans a 4-row x 3-column keypad matrix and samples 4 pushbuttons.
- Debounces the combined 16-bit key state across full sweeps.
- Emits a one-hot 16-bit code plus a single-cycle valid strobe. These feed the display stage's scan_data/valid inputs directly (keypad[15:4], buttons[3:0]).

---
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 keypad column scan plus 4 pushbuttons, debounced
// over whole sweeps, emitting a one-hot key code with a valid strobe.
module keypad_scanner #(
    parameter int SCAN_CNT        = 1000,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    input  logic [3:0]  btn,
    output logic [2:0]  key_col,
    output logic [15:0] scan_data,
    output logic        valid
);
    localparam int DW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int SW = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_CNT - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_SWEEPS);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_SWEEPS - 1);

    typedef enum logic [1:0] {COL0, COL1, COL2} col_t;

    col_t          r_col;
    col_t          w_col_next;
    logic [2:0]    r_key_col;
    logic [2:0]    w_key_col_next;
    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [3:0]    r_btn_s1;
    logic [3:0]    r_btn_s2;
    logic [DW-1:0] r_dwell;
    logic [15:0]   r_snap;
    logic [15:0]   r_prev;
    logic [SW-1:0] r_stable;
    logic [15:0]   r_deb;
    logic          r_fire;
    logic          r_valid;
    logic [15:0]   r_scan_data;

    logic          w_cap;
    logic          w_sweep_end;
    logic [15:0]   w_snap;
    logic          w_same;
    logic [SW-1:0] w_stable_next;
    logic          w_commit;
    logic          w_onehot;
    logic          w_fire;

    assign w_cap       = (r_dwell == DWELL_LAST);
    assign w_sweep_end = w_cap && (r_col == COL2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= COL0;
            r_key_col <= 3'b001;
        end else begin
            r_col     <= w_col_next;
            r_key_col <= w_key_col_next;
        end
    end

    always_comb begin
        w_col_next     = r_col;
        w_key_col_next = r_key_col;
        if (w_cap) begin
            case (r_col)
                COL0: begin
                    w_col_next     = COL1;
                    w_key_col_next = 3'b010;
                end
                COL1: begin
                    w_col_next     = COL2;
                    w_key_col_next = 3'b100;
                end
                default: begin
                    w_col_next     = COL0;
                    w_key_col_next = 3'b001;
                end
            endcase
        end
    end

    // Key (r,c) lands on bit 4+3r+c; buttons ride along with column 2.
    always_comb begin
        w_snap = r_snap;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (r_key_col[c]) w_snap[4 + 3*r + c] = r_row_s2[r];
            end
        end
        if (r_key_col[2]) w_snap[3:0] = r_btn_s2;
    end

    always_comb begin
        w_same        = (w_snap == r_prev);
        w_stable_next = r_stable;
        w_commit      = 1'b0;
        if (!w_same) begin
            w_stable_next = SW'(1);
            w_commit      = (DEBOUNCE_SWEEPS == 1);
        end else if (r_stable != STABLE_MAX) begin
            w_stable_next = r_stable + SW'(1);
            w_commit      = (r_stable == STABLE_LAST);
        end
        w_onehot = (w_snap != 16'h0000) &&
                   ((w_snap & (w_snap - 16'd1)) == 16'h0000);
        w_fire   = w_commit && w_onehot && (w_snap != r_deb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1    <= '0;
            r_row_s2    <= '0;
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_dwell     <= '0;
            r_snap      <= '0;
            r_prev      <= '0;
            r_stable    <= '0;
            r_deb       <= '0;
            r_fire      <= 1'b0;
            r_valid     <= 1'b0;
            r_scan_data <= '0;
        end else begin
            r_row_s1 <= key_row;
            r_row_s2 <= r_row_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_dwell  <= w_cap ? '0 : r_dwell + DW'(1);
            if (w_cap) r_snap <= w_snap;
            r_fire <= 1'b0;
            if (w_sweep_end) begin
                r_stable <= w_stable_next;
                if (!w_same) r_prev <= w_snap;
                if (w_commit) r_deb <= w_snap;
                r_fire <= w_fire;
            end
            // Strobe and data go out one edge after the committing sweep end.
            r_valid <= r_fire;
            if (r_fire) r_scan_data <= r_deb;
        end
    end

    assign key_col   = r_key_col;
    assign scan_data = r_scan_data;
    assign valid     = r_valid;

endmodule
